// File: rtl/register_writeback_queue_pkg.sv
// Shared processor constants and types for the register write-back queue.
// Contents: register address/data widths, the CLK_EN bit that marks the
// register-file write phase, the queued entry type, the round-robin grant
// encoding and a helper that sizes occupancy/pending counters.
package register_writeback_queue_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int CLK_EN_W     = 2;
    localparam int WB_PHASE_BIT = 1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/register_writeback_queue_if.sv
// Bus bundle of the register write-back queue.
// Carries the pipeline phase enables, the ALU and load-result request
// channels (valid/ready/addr/data), the register-file write port, the two
// decode hazard queries with their busy flags, and the occupancy level.
// modport master: the pipeline side driving requests and queries.
// modport slave : the queue itself.
interface register_writeback_queue_if #(
    parameter int DEPTH = 4
);
    import register_writeback_queue_pkg::*;

    localparam int LEVEL_W = level_width(DEPTH);

    logic [CLK_EN_W-1:0] clk_en;
    logic                alu_valid;
    logic                alu_ready;
    reg_addr_t           alu_addr;
    reg_data_t           alu_data;
    logic                mem_valid;
    logic                mem_ready;
    reg_addr_t           mem_addr;
    reg_data_t           mem_data;
    reg_addr_t           write_address;
    reg_data_t           write_data;
    logic                write_enable;
    reg_addr_t           query_addr1;
    reg_addr_t           query_addr2;
    logic                busy1;
    logic                busy2;
    logic [LEVEL_W-1:0]  level;

    modport master (
        output clk_en, alu_valid, alu_addr, alu_data,
               mem_valid, mem_addr, mem_data, query_addr1, query_addr2,
        input  alu_ready, mem_ready, write_address, write_data,
               write_enable, busy1, busy2, level
    );

    modport slave (
        input  clk_en, alu_valid, alu_addr, alu_data,
               mem_valid, mem_addr, mem_data, query_addr1, query_addr2,
        output alu_ready, mem_ready, write_address, write_data,
               write_enable, busy1, busy2, level
    );

endinterface

// File: rtl/register_writeback_queue_fifo.sv
// writeback_fifo: storage, read/write pointers and occupancy for queued
// register writes.
// Ports: clk_i, rst_i (sync, active-high); push_i/push_entry_i enqueue;
// pop_i dequeues the head; head_o shows the head entry (zero when empty);
// level_o occupancy; full_o / empty_o status.
// The caller guarantees no push while full and no pop while empty.
module writeback_fifo
    import register_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  wb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output wb_entry_t                     head_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = level_width(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entries are only visible through level_q, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LEVEL_W'(DEPTH));
    assign level_o = level_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/register_writeback_queue.sv
// register_writeback_queue: merges ALU and load results into one ordered
// stream of register-file writes and reports pending-write hazards.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport) carrying the
// two request channels, the register-file write port, hazard queries and
// the occupancy level.
// Arbitration and per-register pending counters live here; storage lives
// in writeback_fifo.
module register_writeback_queue
    import register_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    register_writeback_queue_if.slave   bus
);

    localparam int LEVEL_W = level_width(DEPTH);
    localparam int NUM_REG = 2 ** REG_ADDR_W;

    grant_e             last_grant_q, last_grant_d;
    logic               grant_alu, grant_mem;
    wb_entry_t          req_entry;
    wb_entry_t          head;
    logic               push, pop;
    logic               full, empty;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] pend_q [NUM_REG];
    logic [LEVEL_W-1:0] pend_d [NUM_REG];

    // Round-robin: on a tie the channel not granted last time wins. The
    // reset value GRANT_MEM makes ALU win the first tie. A full queue
    // grants nothing even if this cycle pops.
    always_comb begin
        grant_alu    = 1'b0;
        grant_mem    = 1'b0;
        last_grant_d = last_grant_q;
        if (!rst_i && !full) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (last_grant_q == GRANT_MEM) grant_alu = 1'b1;
                else                           grant_mem = 1'b1;
            end else if (bus.alu_valid) begin
                grant_alu = 1'b1;
            end else if (bus.mem_valid) begin
                grant_mem = 1'b1;
            end
        end
        if (grant_alu)      last_grant_d = GRANT_ALU;
        else if (grant_mem) last_grant_d = GRANT_MEM;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_grant_q <= GRANT_MEM;
        else       last_grant_q <= last_grant_d;
    end

    assign req_entry = grant_alu ? '{addr: bus.alu_addr, data: bus.alu_data}
                                 : '{addr: bus.mem_addr, data: bus.mem_data};

    // Writes to r0 are handshaken but dropped.
    assign push = (grant_alu || grant_mem) && (req_entry.addr != '0);
    assign pop  = bus.clk_en[WB_PHASE_BIT] && !empty;

    writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_entry_i (req_entry),
        .pop_i        (pop),
        .head_o       (head),
        .level_o      (level),
        .full_o       (full),
        .empty_o      (empty)
    );

    // Entry 0 never moves: addr 0 is never queued, so never popped either.
    always_comb begin
        for (int r = 0; r < NUM_REG; r++) begin
            pend_d[r] = pend_q[r];
            case ({push && (req_entry.addr == REG_ADDR_W'(r)),
                   pop  && (head.addr      == REG_ADDR_W'(r))})
                2'b10:   pend_d[r] = pend_q[r] + LEVEL_W'(1);
                2'b01:   pend_d[r] = pend_q[r] - LEVEL_W'(1);
                default: pend_d[r] = pend_q[r];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REG; r++) begin
            if (rst_i) pend_q[r] <= '0;
            else       pend_q[r] <= pend_d[r];
        end
    end

    assign bus.alu_ready     = grant_alu;
    assign bus.mem_ready     = grant_mem;
    assign bus.write_address = head.addr;
    assign bus.write_data    = head.data;
    assign bus.write_enable  = !empty;
    assign bus.level         = level;
    assign bus.busy1 = (bus.query_addr1 != '0) && (pend_q[bus.query_addr1] != '0);
    assign bus.busy2 = (bus.query_addr2 != '0) && (pend_q[bus.query_addr2] != '0);

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed bench for register_writeback_queue with a scoreboard of the
// expected register-file writes and a behavioural arbitration/pending model.
module tb_register_writeback_queue;
    import register_writeback_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    register_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int        checks = 0;
    int        errors = 0;
    wb_entry_t sb[$];
    int        pend[32];
    logic      m_last_mem;
    logic      g_alu, g_mem;
    logic      obs_alu_ready, obs_mem_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs against the model,
    // advance the model, then move to 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [1:0] ce,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] q1, input logic [4:0] q2);
        wb_entry_t e;
        logic      full;
        rst = r;
        bus.clk_en = ce;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.query_addr1 = q1; bus.query_addr2 = q2;
        #3;
        full  = (sb.size() == DEPTH);
        g_alu = 1'b0;
        g_mem = 1'b0;
        if (!r && !full) begin
            if (av && mv) begin
                g_alu = m_last_mem;
                g_mem = !m_last_mem;
            end else begin
                g_alu = av;
                g_mem = !av && mv;
            end
        end
        obs_alu_ready = bus.alu_ready;
        obs_mem_ready = bus.mem_ready;
        check("alu_ready", bus.alu_ready, g_alu);
        check("mem_ready", bus.mem_ready, g_mem);
        check("level", 32'(bus.level), sb.size());
        check("write_enable", bus.write_enable, sb.size() != 0);
        if (sb.size() != 0) begin
            check("write_address", bus.write_address, sb[0].addr);
            check("write_data", bus.write_data, sb[0].data);
        end else begin
            check("write_address_idle", bus.write_address, 0);
            check("write_data_idle", bus.write_data, 0);
        end
        check("busy1", bus.busy1, (q1 != 0) && (pend[q1] != 0));
        check("busy2", bus.busy2, (q2 != 0) && (pend[q2] != 0));
        if (r) begin
            sb.delete();
            foreach (pend[i]) pend[i] = 0;
            m_last_mem = 1'b1;
        end else begin
            if (ce[1] && sb.size() != 0) begin
                e = sb.pop_front();
                pend[e.addr]--;
            end
            if (g_alu || g_mem) begin
                e.addr = g_alu ? aa : ma;
                e.data = g_alu ? ad : md;
                if (e.addr != 0) begin
                    sb.push_back(e);
                    pend[e.addr]++;
                end
                m_last_mem = g_mem;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] ce, input logic [4:0] q1, input logic [4:0] q2);
        step(1'b0, ce, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
    endtask

    initial begin
        int na;
        int nm;
        bus.clk_en = 2'b00;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h1;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h2;
        bus.query_addr1 = 5'd0; bus.query_addr2 = 5'd0;
        foreach (pend[i]) pend[i] = 0;
        m_last_mem = 1'b1;

        // Power-on reset: READY must stay low while reset is asserted.
        rst = 1'b1;
        #2;
        check("ready_in_reset_alu", bus.alu_ready, 1'b0);
        check("ready_in_reset_mem", bus.mem_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_level", 32'(bus.level), 0);
        check("reset_we", bus.write_enable, 1'b0);

        // Single ALU push held three cycles, then popped on write phase.
        step(1'b0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        repeat (3) idle(2'b00, 5'd5, 5'd0);
        check("hold_addr", bus.write_address, 5'd5);
        idle(2'b01, 5'd5, 5'd0);
        idle(2'b10, 5'd5, 5'd0);
        check("busy_clear_after_pop", bus.busy1, 1'b0);
        idle(2'b00, 5'd5, 5'd5);

        // Write to r0 is accepted and dropped.
        step(1'b0, 2'b00, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("r0_level", 32'(bus.level), 0);
        check("r0_we", bus.write_enable, 1'b0);

        // Reset so the next tie goes to ALU, then four contested pushes.
        step(1'b1, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        na = 0;
        nm = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 1'b1, 5'(1 + na), 32'h100 + 32'(na),
                 1'b1, 5'(9 + nm), 32'h200 + 32'(nm), 5'd1, 5'd9);
            check("rr_alternate_alu", obs_alu_ready, (i % 2) == 0);
            check("rr_alternate_mem", obs_mem_ready, (i % 2) == 1);
            if (g_alu) na++;
            if (g_mem) nm++;
        end
        check("full_level", 32'(bus.level), 4);
        step(1'b0, 2'b00, 1'b1, 5'd3, 32'h300, 1'b1, 5'd11, 32'h400, 5'd2, 5'd10);

        // Full with pop and valid together: no pop-through.
        step(1'b0, 2'b10, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'd0, 5'd1, 5'd3);
        check("full_pop_level", 32'(bus.level), 3);
        step(1'b0, 2'b00, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'd0, 5'd3, 5'd1);
        check("refill_level", 32'(bus.level), 4);
        repeat (5) idle(2'b10, 5'd3, 5'd10);
        check("drained_we", bus.write_enable, 1'b0);

        // Two writes to r7 drain; then push/pop of r7 in the same cycle.
        step(1'b0, 2'b00, 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB, 5'd7, 5'd0);
        idle(2'b10, 5'd7, 5'd0);
        check("busy7_after_one_pop", bus.busy1, 1'b1);
        idle(2'b10, 5'd7, 5'd0);
        check("busy7_after_two_pops", bus.busy1, 1'b0);
        step(1'b0, 2'b00, 1'b1, 5'd7, 32'hC, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
        step(1'b0, 2'b10, 1'b1, 5'd7, 32'hD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
        check("busy7_pushpop", bus.busy2, 1'b1);
        idle(2'b10, 5'd0, 5'd7);
        idle(2'b00, 5'd7, 5'd7);

        // Reset mid-drain with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b00, 1'b1, 5'(20 + i), 32'h500 + 32'(i),
                 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
        check("pre_reset_level", 32'(bus.level), 3);
        step(1'b1, 2'b10, 1'b1, 5'd25, 32'h600, 1'b1, 5'd26, 32'h700, 5'd20, 5'd22);
        check("post_reset_level", 32'(bus.level), 0);
        check("post_reset_we", bus.write_enable, 1'b0);
        check("post_reset_busy", bus.busy1, 1'b0);
        step(1'b0, 2'b00, 1'b1, 5'd25, 32'h600, 1'b1, 5'd26, 32'h700, 5'd20, 5'd21);
        check("post_reset_tie_alu", obs_alu_ready, 1'b1);
        idle(2'b10, 5'd25, 5'd26);
        idle(2'b00, 5'd25, 5'd26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_writeback_queue.md
REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queued write entries; legal values are 2, 4 and 8.
REQ-002 Port CLK input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port RST input 1: reset, synchronous and active-high.
REQ-004 Port CLK_EN input 2: pipeline phase enables; bit 1 is the register-file write phase.
REQ-005 Ports ALU_VALID input 1, ALU_READY output 1, ALU_ADDR input 5, ALU_DATA input 32: ALU result write request channel.
REQ-006 Ports MEM_VALID input 1, MEM_READY output 1, MEM_ADDR input 5, MEM_DATA input 32: load result write request channel.
REQ-007 Ports WRITE_ADDRESS output 5, WRITE_DATA output 32, WRITE_ENABLE output 1: drive the register file write port.
REQ-008 Ports QUERY_ADDR1 input 5, QUERY_ADDR2 input 5, BUSY1 output 1, BUSY2 output 1: pending-write hazard query for the two decode read addresses.
REQ-009 Port LEVEL output log2(DEPTH)+1: current queue occupancy.

Function
REQ-010 A request SHALL transfer on a cycle where VALID and READY are both high on that channel.
REQ-011 At most one request SHALL be granted per cycle; READY SHALL be high only for the granted channel and only when LEVEL < DEPTH (no pop-through when full).
REQ-012 Arbitration SHALL be round-robin: with both VALID high, the channel not granted most recently wins; after reset ALU wins the first tie.
REQ-013 With only one VALID high and queue not full, that channel SHALL be granted.
REQ-014 A transferred request with ADDR = 0 SHALL be accepted and discarded (never queued, never counted).
REQ-015 Queue SHALL be FIFO; entries SHALL reach the register file in acceptance order.
REQ-016 WRITE_ADDRESS/WRITE_DATA SHALL present the head entry combinationally; WRITE_ENABLE SHALL equal (LEVEL != 0).
REQ-017 The head entry SHALL be popped at the end of any cycle with CLK_EN[1] = 1 and LEVEL != 0; CLK_EN[0] alone SHALL NOT pop.
REQ-018 When empty, WRITE_ADDRESS and WRITE_DATA SHALL be 0.
REQ-019 Simultaneous push and pop SHALL leave LEVEL unchanged; push into an empty queue SHALL appear on WRITE_* the following cycle (one-cycle latency).
REQ-020 Read/write pointers SHALL wrap modulo DEPTH.
REQ-021 A pending counter per register (1..31), width log2(DEPTH)+1, SHALL increment on a queued push, decrement on pop, both or neither when push and pop target the same register.
REQ-022 BUSYn SHALL be high combinationally when the counter of QUERY_ADDRn is nonzero; QUERY_ADDRn = 0 SHALL give BUSYn = 0.
REQ-023 A register whose last pending entry pops in cycle N SHALL read BUSY = 0 from cycle N+1.

Reset
REQ-024 With RST high at a clock edge, pointers, LEVEL, all pending counters and the round-robin state SHALL clear; outputs next cycle: WRITE_ENABLE 0, WRITE_ADDRESS 0, WRITE_DATA 0, BUSY1/BUSY2 0, LEVEL 0.
REQ-025 READY outputs SHALL be 0 while RST is high; a reset mid-drain SHALL discard all queued entries without writing them.

Structure
REQ-026 Register address width (5), data width (32) and the write-phase bit index of CLK_EN SHALL be constants in the shared processor package.
REQ-027 Storage, pointers and LEVEL SHALL live in one sub-module, writeback_fifo; arbitration and the pending counters stay in the top.

Verification
REQ-028 Single ALU push (addr 5, data 0xDEADBEEF), CLK_EN = 2'b00 for 3 cycles then 2'b10 -> WRITE_ENABLE held high 3 cycles with addr 5, pop on the first CLK_EN[1] cycle, BUSY for addr 5 high until the cycle after the pop.
REQ-029 ALU and MEM both VALID for 4 cycles (ALU addr 1..4, MEM addr 9..12), no pops -> grants alternate ALU, MEM, ALU, MEM; LEVEL 4; both READY 0 afterwards.
REQ-030 Full queue with pop and VALID in the same cycle -> READY stays 0 that cycle; LEVEL 3 then 4 on the next cycle's push.
REQ-031 Push addr 0 data 0x1234 -> accepted, LEVEL stays 0, WRITE_ENABLE stays 0.
REQ-032 Two pushes to addr 7 then continuous CLK_EN = 2'b10 -> BUSY high through 2 pops, low after; push addr 7 coincident with pop of addr 7 keeps counter at 1.
REQ-033 RST asserted with LEVEL 3 -> next cycle LEVEL 0, WRITE_ENABLE 0, all BUSY 0, first post-reset tie granted to ALU.
